// File: rtl/blade_pkg.sv
// Shared types and constants for the blade arbiter and its bounce scanner.
package blade_pkg;

  localparam int LED_W = 6;

  typedef logic [LED_W-1:0] blade_t;

  localparam blade_t BLADE_OFF = 6'b111_111;
  localparam blade_t LED_ONE   = 6'b000_001;

  typedef enum logic {SCAN, SHOW} blade_state_t;

  // Active-low image with only the LED at pos dark... i.e. pos lit-off inverted: one LED lit-low, rest high
  function automatic blade_t dark_led(input logic [2:0] pos);
    return ~(LED_ONE << pos);
  endfunction

endpackage

// File: rtl/blade_scanner.sv
// Idle bounce scanner: a single active LED walking 0..5..0, one position per step.
module blade_scanner
  import blade_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  output blade_t image
);

  logic [2:0] pos_r;
  logic       dir_left_r;
  logic [2:0] pos_nxt_s;
  logic       dir_left_nxt_s;

  // Bounce: reverse direction on arrival at either end so each end shows for one step
  always_comb begin
    pos_nxt_s      = pos_r;
    dir_left_nxt_s = dir_left_r;
    if (step) begin
      if (dir_left_r && (pos_r < 3'd5)) begin
        pos_nxt_s      = pos_r + 3'd1;
        dir_left_nxt_s = (pos_r != 3'd4);
      end else if (pos_r > 3'd0) begin
        pos_nxt_s      = pos_r - 3'd1;
        dir_left_nxt_s = (pos_r == 3'd1);
      end else begin
        pos_nxt_s      = 3'd1;
        dir_left_nxt_s = 1'b1;
      end
    end else begin
      pos_nxt_s      = pos_r;
      dir_left_nxt_s = dir_left_r;
    end
  end

  // Position and direction state
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_r      <= 3'd0;
      dir_left_r <= 1'b1;
    end else begin
      pos_r      <= pos_nxt_s;
      dir_left_r <= dir_left_nxt_s;
    end
  end

  // Image of the position after this cycle's step, so the top can register it in step
  assign image = dark_led(pos_nxt_s);

endmodule

// File: rtl/blade_arbiter.sv
// Blade LED arbiter: round-robin display of requester patterns, bounce scanner when idle.
// Define BLADE_PREEMPT_EN to let requester 0 preempt another requester's display.
module blade_arbiter
  import blade_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int PRESCALE_W = 22,
  parameter int HOLD_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*LED_W-1:0]  req_pattern,
  input  logic [NUM_REQ*HOLD_W-1:0] req_hold,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      scan_en,
  output blade_t                    blade,
  output logic                      busy,
  output logic [2:0]                grant_id
);

  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1'b1);
  localparam logic [2:0]        LAST_REQ = 3'(NUM_REQ - 1);

  logic [PRESCALE_W-1:0] presc_r;
  logic                  tick_s;
  blade_state_t          state_r;
  logic [2:0]            rr_ptr_r;
  logic [HOLD_W-1:0]     hold_r;
  blade_t                disp_r;
  blade_t                blade_r;
  logic                  busy_r;
  logic [2:0]            grant_id_r;

  logic [NUM_REQ-1:0]    rr_ready_s;
  logic [2:0]            rr_idx_s;
  logic [NUM_REQ-1:0]    ready_s;
  logic                  preempt_s;
  logic                  hs_s;
  logic [2:0]            hs_idx_s;
  blade_t                hs_pattern_s;
  logic [HOLD_W-1:0]     hs_hold_s;
  logic [HOLD_W-1:0]     hs_hold_norm_s;
  logic                  step_s;
  blade_t                scan_image_s;

  // Free-running prescaler
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= {PRESCALE_W{1'b0}};
    end else begin
      presc_r <= presc_r + PRESCALE_W'(1'b1);
    end
  end

  assign tick_s = &presc_r;

  // Round-robin search from rr_ptr upward; later assignments carry higher priority
  always_comb begin
    rr_ready_s = {NUM_REQ{1'b0}};
    rr_idx_s   = 3'd0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (j < int'(rr_ptr_r))) begin
        rr_ready_s    = {NUM_REQ{1'b0}};
        rr_ready_s[j] = 1'b1;
        rr_idx_s      = 3'(j);
      end else begin
        rr_idx_s = rr_idx_s;
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (j >= int'(rr_ptr_r))) begin
        rr_ready_s    = {NUM_REQ{1'b0}};
        rr_ready_s[j] = 1'b1;
        rr_idx_s      = 3'(j);
      end else begin
        rr_idx_s = rr_idx_s;
      end
    end
  end

  // Ready is the round-robin grant in SCAN; only a preempting requester 0 may see ready in SHOW
  always_comb begin
    ready_s   = {NUM_REQ{1'b0}};
    preempt_s = 1'b0;
    if (reset) begin
      ready_s = {NUM_REQ{1'b0}};
    end else if (state_r == SCAN) begin
      ready_s = rr_ready_s;
`ifdef BLADE_PREEMPT_EN
    end else if ((grant_id_r != 3'd0) && req_valid[0]) begin
      ready_s[0] = 1'b1;
      preempt_s  = 1'b1;
`endif
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready = ready_s;
  assign hs_s      = |(req_valid & ready_s);
  assign hs_idx_s  = preempt_s ? 3'd0 : rr_idx_s;

  // Steer the handshaking requester's pattern and hold onto shared buses
  always_comb begin
    hs_pattern_s = BLADE_OFF;
    hs_hold_s    = {HOLD_W{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == hs_idx_s) begin
        hs_pattern_s = req_pattern[j*LED_W +: LED_W];
        hs_hold_s    = req_hold[j*HOLD_W +: HOLD_W];
      end else begin
        hs_pattern_s = hs_pattern_s;
      end
    end
  end

  assign hs_hold_norm_s = (hs_hold_s == {HOLD_W{1'b0}}) ? HOLD_ONE : hs_hold_s;
  assign step_s         = tick_s & scan_en & (state_r == SCAN) & ~hs_s;

  blade_scanner u_scanner (
    .clk   (clk),
    .reset (reset),
    .step  (step_s),
    .image (scan_image_s)
  );

  // Arbitration FSM with registered blade, busy and grant outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= SCAN;
      rr_ptr_r   <= 3'd0;
      hold_r     <= {HOLD_W{1'b0}};
      disp_r     <= BLADE_OFF;
      blade_r    <= BLADE_OFF;
      busy_r     <= 1'b0;
      grant_id_r <= 3'd0;
    end else begin
      case (state_r)
        SCAN: begin
          if (hs_s) begin
            state_r    <= SHOW;
            disp_r     <= ~hs_pattern_s;
            blade_r    <= ~hs_pattern_s;
            hold_r     <= hs_hold_norm_s;
            busy_r     <= 1'b1;
            grant_id_r <= hs_idx_s;
            rr_ptr_r   <= (rr_idx_s == LAST_REQ) ? 3'd0 : rr_idx_s + 3'd1;
          end else begin
            blade_r    <= scan_en ? scan_image_s : BLADE_OFF;
            busy_r     <= 1'b0;
            grant_id_r <= 3'd0;
          end
        end
        SHOW: begin
          if (hs_s) begin
            disp_r     <= ~hs_pattern_s;
            blade_r    <= ~hs_pattern_s;
            hold_r     <= hs_hold_norm_s;
            grant_id_r <= hs_idx_s;
          end else if (tick_s) begin
            if (hold_r > HOLD_ONE) begin
              hold_r <= hold_r - HOLD_ONE;
            end else begin
              // Scanner was frozen, so its image is the saved position
              hold_r     <= {HOLD_W{1'b0}};
              state_r    <= SCAN;
              blade_r    <= scan_en ? scan_image_s : BLADE_OFF;
              busy_r     <= 1'b0;
              grant_id_r <= 3'd0;
            end
          end else begin
            hold_r <= hold_r;
          end
        end
        default: begin
          state_r    <= SCAN;
          blade_r    <= BLADE_OFF;
          busy_r     <= 1'b0;
          grant_id_r <= 3'd0;
        end
      endcase
    end
  end

  assign blade    = blade_r;
  assign busy     = busy_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_blade_arbiter.sv
// Self-checking bench for blade_arbiter: vector table, directed sequences, randomized run vs reference model.
module tb_blade_arbiter;

  localparam int NREQ = 3;
  localparam int PW   = 4;
  localparam int HW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [17:0] req_pattern;
  logic [11:0] req_hold;
  logic [2:0]  req_ready;
  logic        scan_en;
  logic [5:0]  blade;
  logic        busy;
  logic [2:0]  grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blade_arbiter #(.NUM_REQ(NREQ), .PRESCALE_W(PW), .HOLD_W(HW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_pattern (req_pattern),
    .req_hold    (req_hold),
    .req_ready   (req_ready),
    .scan_en     (scan_en),
    .blade       (blade),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  // Reference model: bounce positions as a lookup sequence, prescaler as a cycle count mod 16
  int         bounce [10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};
  bit         m_show;
  int         m_cnt, m_ptr, m_hold, m_grant, m_seq_i;
  logic [5:0] m_disp, m_blade;
  bit         m_busy;
  logic [2:0] m_hs_mask;

  function automatic logic [5:0] model_img();
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << bounce[m_seq_i]);
  endfunction

  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    r = 3'b000;
    if (reset) return 3'b000;
    if (!m_show) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (req_valid[i]) begin
          r[i] = 1'b1;
          return r;
        end
      end
    end
`ifdef BLADE_PREEMPT_EN
    else if (m_grant != 0 && req_valid[0]) r[0] = 1'b1;
`endif
    return r;
  endfunction

  task automatic model_edge();
    logic [2:0] hs;
    int idx;
    bit tick;
    hs = model_ready() & req_valid;
    m_hs_mask = hs;
    if (reset) begin
      m_show = 0; m_cnt = 0; m_ptr = 0; m_hold = 0; m_grant = 0; m_seq_i = 0;
      m_blade = 6'h3F; m_busy = 0; m_hs_mask = 3'b000;
      return;
    end
    tick = (m_cnt == 15);
    m_cnt = (m_cnt + 1) % 16;
    idx = -1;
    for (int i = 0; i < NREQ; i++) if (hs[i]) idx = i;
    if (idx >= 0) begin
      m_disp = ~req_pattern[6*idx +: 6];
      m_hold = int'(req_hold[4*idx +: 4]);
      if (m_hold == 0) m_hold = 1;
      if (!m_show) m_ptr = (idx + 1) % NREQ;
      m_show = 1;
      m_grant = idx;
    end else if (m_show) begin
      if (tick) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_show = 0;
      end
    end else if (tick && scan_en) begin
      m_seq_i = (m_seq_i + 1) % 10;
    end
    if (!m_show) m_grant = 0;
    m_busy  = m_show;
    m_blade = m_show ? m_disp : (scan_en ? model_img() : 6'h3F);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after it
  task automatic cyc();
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(model_ready()));
    model_edge();
    @(posedge clk);
    #1;
    chk("blade", 32'(blade), 32'(m_blade));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 3'b000;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] valid;
    logic       scan;
    logic [2:0] ready;
    logic [5:0] blade;
    logic       busy;
    logic [2:0] gid;
  } vec_t;

  vec_t        vecs [6];
  int          grants [$];
  bit          prev_busy;
  logic [2:0]  exp_ready0;

  initial begin
    reset = 1'b1; req_valid = 3'b000; scan_en = 1'b1;
    req_pattern = {6'b111111, 6'b000011, 6'b101010};
    req_hold    = {4'd0, 4'd2, 4'd3};

    // First cycle after reset: one applied input vector, expectations from the rules directly
    vecs[0] = '{3'b010, 1'b1, 3'b010, 6'b111100, 1'b1, 3'd1};
    vecs[1] = '{3'b000, 1'b1, 3'b000, 6'b111110, 1'b0, 3'd0};
    vecs[2] = '{3'b000, 1'b0, 3'b000, 6'b111111, 1'b0, 3'd0};
    vecs[3] = '{3'b111, 1'b1, 3'b001, 6'b010101, 1'b1, 3'd0};
    vecs[4] = '{3'b110, 1'b0, 3'b010, 6'b111100, 1'b1, 3'd1};
    vecs[5] = '{3'b100, 1'b1, 3'b100, 6'b000000, 1'b1, 3'd2};

    do_reset();
    chk("reset_blade", 32'(blade), 32'h3F);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_gid", 32'(grant_id), 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      req_valid = vecs[v].valid;
      scan_en   = vecs[v].scan;
      #2;
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].ready));
      cyc();
      chk($sformatf("vec%0d_blade", v), 32'(blade), 32'(vecs[v].blade));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
      chk($sformatf("vec%0d_gid", v), 32'(grant_id), 32'(vecs[v].gid));
      req_valid = 3'b000;
    end
    scan_en = 1'b1;

    // Idle bounce: one step per 16 clocks
    do_reset();
    repeat (15) cyc();
    chk("scan_pos0", 32'(blade), 32'h3E);
    cyc();
    chk("scan_pos1", 32'(blade), 32'h3D);
    repeat (64) cyc();
    chk("scan_pos5", 32'(blade), 32'h1F);
    repeat (16) cyc();
    chk("scan_back4", 32'(blade), 32'h2F);

    // Single request, hold 2: returns on the second tick, scanner resumes from saved position
    do_reset();
    req_valid = 3'b010;
    cyc();
    req_valid = 3'b000;
    repeat (30) cyc();
    chk("hold2_busy31", 32'(busy), 32'd1);
    cyc();
    chk("hold2_busy32", 32'(busy), 32'd0);
    chk("hold2_resume", 32'(blade), 32'h3E);
    repeat (16) cyc();
    chk("hold2_step", 32'(blade), 32'h3D);

    // hold=0 on req 2 behaves as hold=1
    do_reset();
    req_valid = 3'b100;
    cyc();
    req_valid = 3'b000;
    repeat (14) cyc();
    chk("hold0_busy15", 32'(busy), 32'd1);
    cyc();
    chk("hold0_busy16", 32'(busy), 32'd0);

    // All three valid: grant order 0,1,2,0
    do_reset();
    req_hold = {4'd1, 4'd1, 4'd1};
    req_valid = 3'b111;
    prev_busy = 1'b0;
    grants.delete();
    for (int n = 0; n < 300 && grants.size() < 4; n++) begin
      cyc();
      if (busy && !prev_busy) grants.push_back(int'(grant_id));
      prev_busy = busy;
    end
    chk("rr_count", 32'(grants.size()), 32'd4);
    for (int g = 0; g < grants.size() && g < 4; g++)
      chk($sformatf("rr_order%0d", g), 32'(grants[g]), 32'(g % 3));
    req_valid = 3'b000;

    // Reset mid-SHOW
    do_reset();
    req_hold = {4'd0, 4'd8, 4'd3};
    req_valid = 3'b010;
    cyc();
    req_valid = 3'b000;
    repeat (20) cyc();
    reset = 1'b1;
    cyc();
    chk("midrst_blade", 32'(blade), 32'h3F);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    repeat (15) cyc();
    chk("midrst_scan", 32'(blade), 32'h3E);

    // Requester 0 pulses while requester 1 is showing
    do_reset();
    req_valid = 3'b010;
    cyc();
    req_valid = 3'b000;
    repeat (5) cyc();
    req_valid = 3'b001;
`ifdef BLADE_PREEMPT_EN
    exp_ready0 = 3'b001;
`else
    exp_ready0 = 3'b000;
`endif
    #2;
    chk("preempt_ready", 32'(req_ready), 32'(exp_ready0));
    cyc();
    req_valid = 3'b000;
`ifdef BLADE_PREEMPT_EN
    chk("preempt_gid", 32'(grant_id), 32'd0);
    chk("preempt_blade", 32'(blade), 32'h15);
`else
    chk("preempt_gid", 32'(grant_id), 32'd1);
    chk("preempt_blade", 32'(blade), 32'h3C);
`endif
    repeat (5) cyc();

    // Randomized requesters against the reference model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [2:0] v;
      v = req_valid;
      for (int i = 0; i < NREQ; i++) begin
        if (m_hs_mask[i] && ($urandom_range(0, 3) != 0)) v[i] = 1'b0;
        if (!v[i] && ($urandom_range(0, 7) == 0)) begin
          v[i] = 1'b1;
          req_pattern[6*i +: 6] = 6'($urandom);
          req_hold[4*i +: 4]    = 4'($urandom_range(0, 3));
        end else if (v[i] && ($urandom_range(0, 63) == 0)) begin
          v[i] = 1'b0;
        end
      end
      req_valid = v;
      if ($urandom_range(0, 63) == 0) scan_en = ~scan_en;
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
